ps2_rx_fifo: RTL and testbench

//  Parametrised PS/2 device-to-host receiver: filters PS/2 clock, deframes 11-bit frames
//  (start, 8 data LSB-first, odd parity, stop), validates stop bit, aborts on inter-bit timeout,

---
 rtl/ps2_rx_fifo.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with clock filter, frame checker and FWFT byte FIFO.
// Define PS2_RX_PARITY_CHECK_EN to enable odd-parity checking and the o_parity_err output.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FIFO_ADDR_W    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_ps2d,
    input  logic                 i_ps2c,
    input  logic                 i_rx_en,
    input  logic                 i_rd,
    output logic [7:0]           o_data,
    output logic                 o_empty,
    output logic                 o_full,
    output logic [FIFO_ADDR_W:0] o_count,
    output logic                 o_rx_done_tick,
    output logic                 o_frame_err,
    output logic                 o_overflow
`ifdef PS2_RX_PARITY_CHECK_EN
    ,
    output logic                 o_parity_err
`endif
);

    localparam int TW    = $clog2(TIMEOUT_CYCLES);
    localparam int DEPTH = 2 ** FIFO_ADDR_W;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FIFO_ADDR_W:0] CNT_FULL = (FIFO_ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RX,
        S_CHECK
    } state_t;

    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_reg;
    logic                  filt_next;
    logic                  fall;
    logic [1:0]            d_sync;
    logic                  ps2d;

    state_t                state;
    state_t                state_nx;
    logic [3:0]            bitcnt;
    logic [3:0]            bitcnt_nx;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         timer_nx;
    logic [7:0]            data_sr;
    logic                  stop_bit;
    logic                  shift_en;
    logic                  par_ok;
    logic                  push;
    logic                  pop;
    logic                  done_nx;
    logic                  ferr_nx;
    logic                  ovf_nx;
    logic                  perr_nx;

    logic [7:0]             mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr;
    logic [FIFO_ADDR_W-1:0] rd_ptr;
    logic [FIFO_ADDR_W:0]   count;

    // Filtered clock only moves once the whole window agrees.
    always_comb begin
        filt_next = filt_reg;
        if (&filt_sr)
            filt_next = 1'b1;
        else if (~|filt_sr)
            filt_next = 1'b0;
    end

    assign fall = filt_reg & ~filt_next;
    assign ps2d = d_sync[1];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            filt_sr  <= '1;
            filt_reg <= 1'b1;
            d_sync   <= 2'b11;
        end else begin
            filt_sr  <= {filt_sr[FILTER_LEN-2:0], i_ps2c};
            filt_reg <= filt_next;
            d_sync   <= {d_sync[0], i_ps2d};
        end
    end

`ifdef PS2_RX_PARITY_CHECK_EN
    logic par_bit;

    assign par_ok = ^{data_sr, par_bit};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            par_bit <= 1'b0;
        else if (shift_en && bitcnt == 4'd8)
            par_bit <= ps2d;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            o_parity_err <= 1'b0;
        else
            o_parity_err <= perr_nx;
    end
`else
    assign par_ok = 1'b1;
`endif

    assign pop      = i_rd & ~o_empty;
    assign shift_en = (state == S_RX) & fall;

    always_comb begin
        state_nx  = state;
        bitcnt_nx = bitcnt;
        timer_nx  = timer;
        push      = 1'b0;
        done_nx   = 1'b0;
        ferr_nx   = 1'b0;
        ovf_nx    = 1'b0;
        perr_nx   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (fall && i_rx_en && !ps2d) begin
                    state_nx  = S_RX;
                    bitcnt_nx = 4'd0;
                    timer_nx  = '0;
                end
            end
            S_RX: begin
                if (fall) begin
                    timer_nx  = '0;
                    bitcnt_nx = bitcnt + 4'd1;
                    if (bitcnt == 4'd9)
                        state_nx = S_CHECK;
                end else if (timer == T_LAST) begin
                    state_nx = S_IDLE;
                    timer_nx = '0;
                    ferr_nx  = 1'b1;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            S_CHECK: begin
                state_nx = S_IDLE;
                if (!stop_bit)
                    ferr_nx = 1'b1;
                else if (!par_ok)
                    perr_nx = 1'b1;
                else if (!o_full || pop) begin
                    push    = 1'b1;
                    done_nx = 1'b1;
                end else
                    ovf_nx = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Data bits shift in LSB-first; parity and stop land in their own flops.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= S_IDLE;
            bitcnt   <= '0;
            timer    <= '0;
            data_sr  <= '0;
            stop_bit <= 1'b0;
        end else begin
            state  <= state_nx;
            bitcnt <= bitcnt_nx;
            timer  <= timer_nx;
            if (shift_en && !bitcnt[3])
                data_sr <= {ps2d, data_sr[7:1]};
            if (shift_en && bitcnt == 4'd9)
                stop_bit <= ps2d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rx_done_tick <= 1'b0;
            o_frame_err    <= 1'b0;
            o_overflow     <= 1'b0;
        end else begin
            o_rx_done_tick <= done_nx;
            o_frame_err    <= ferr_nx;
            o_overflow     <= ovf_nx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= data_sr;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + FIFO_ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_ADDR_W'(1);
            if (push && !pop)
                count <= count + (FIFO_ADDR_W + 1)'(1);
            else if (pop && !push)
                count <= count - (FIFO_ADDR_W + 1)'(1);
        end
    end

    assign o_data  = mem[rd_ptr];
    assign o_empty = (count == '0);
    assign o_full  = (count == CNT_FULL);
    assign o_count = count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: PS/2 frame driver, byte scoreboard, pulse counters.
// Covers both builds of PS2_RX_PARITY_CHECK_EN.
module tb_ps2_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic       ps2d;
    logic       ps2c;
    logic       rx_en;
    logic       rd;
    logic [7:0] data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       done_tick;
    logic       frame_err;
    logic       overflow;
`ifdef PS2_RX_PARITY_CHECK_EN
    logic       parity_err;
`endif

    ps2_rx_fifo #(
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(2000),
        .FIFO_ADDR_W   (2)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_ps2d        (ps2d),
        .i_ps2c        (ps2c),
        .i_rx_en       (rx_en),
        .i_rd          (rd),
        .o_data        (data),
        .o_empty       (empty),
        .o_full        (full),
        .o_count       (count),
        .o_rx_done_tick(done_tick),
        .o_frame_err   (frame_err),
        .o_overflow    (overflow)
`ifdef PS2_RX_PARITY_CHECK_EN
        ,
        .o_parity_err  (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_ovf  = 0;
    int n_perr = 0;
    int e_done = 0;
    int e_err  = 0;
    int e_ovf  = 0;
    int e_perr = 0;
    logic [7:0] q[$];
    logic [7:0] exp_head;

    always @(negedge clk) begin
        if (done_tick) n_done++;
        if (frame_err) n_err++;
        if (overflow)  n_ovf++;
`ifdef PS2_RX_PARITY_CHECK_EN
        if (parity_err) n_perr++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pulses(input string tag);
        chk({tag, "_done"}, n_done, e_done);
        chk({tag, "_ferr"}, n_err, e_err);
        chk({tag, "_ovf"}, n_ovf, e_ovf);
        chk({tag, "_perr"}, n_perr, e_perr);
    endtask

    task automatic fifo_state(input string tag);
        chk({tag, "_count"}, count, q.size());
        chk({tag, "_empty"}, empty, q.size() == 0);
        chk({tag, "_full"}, full, q.size() == 4);
    endtask

    // One PS/2 frame, 200-cycle bit period; optional glitch and pop on the CHECK cycle.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int nbits, input bit rd_chk, input int glitch_bit);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = f[i];
            repeat (50) @(negedge clk);
            if (i == glitch_bit) begin
                ps2c = 1'b0;
                repeat (7) @(negedge clk);
                ps2c = 1'b1;
                repeat (20) @(negedge clk);
            end
            ps2c = 1'b0;
            for (int j = 1; j <= 100; j++) begin
                @(negedge clk);
                if (rd_chk && i == 10 && j == 9) begin
                    chk("rd_head", data, exp_head);
                    rd = 1'b1;
                end else
                    rd = 1'b0;
            end
            ps2c = 1'b1;
            repeat (50) @(negedge clk);
        end
        ps2d = 1'b1;
    endtask

    task automatic good(input logic [7:0] d);
        send_frame(d, ~^d, 1'b1, 11, 1'b0, -1);
        if (q.size() < 4) begin
            q.push_back(d);
            e_done++;
        end else
            e_ovf++;
        repeat (20) @(negedge clk);
    endtask

    task automatic read_one(input string tag);
        logic [7:0] e;
        chk({tag, "_nonempty"}, empty, 1'b0);
        e = q.pop_front();
        chk({tag, "_data"}, data, e);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        rx_en = 1'b1;
        rd    = 1'b0;
        repeat (5) @(negedge clk);
        fifo_state("rst");
        pulses("rst");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        good(8'h1C);
        fifo_state("t1");
        pulses("t1");
        read_one("t1");
        fifo_state("t1_rd");

        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, -1);
`ifdef PS2_RX_PARITY_CHECK_EN
        e_perr++;
`else
        q.push_back(8'h1C);
        e_done++;
`endif
        repeat (20) @(negedge clk);
        pulses("t2");
        fifo_state("t2");
        if (q.size() != 0) read_one("t2");

        send_frame(8'hF0, 1'b1, 1'b0, 11, 1'b0, -1);
        e_err++;
        repeat (20) @(negedge clk);
        pulses("t3_stop");
        fifo_state("t3_stop");
        good(8'hF0);
        read_one("t3");

        send_frame(8'h00, 1'b0, 1'b1, 5, 1'b0, -1);
        repeat (1500) @(negedge clk);
        pulses("t4_early");
        repeat (600) @(negedge clk);
        e_err++;
        pulses("t4_tmo");
        good(8'h5A);
        pulses("t4");
        read_one("t4");

        for (int k = 1; k <= 5; k++) begin
            good(8'(k));
            fifo_state($sformatf("t5_fill%0d", k));
        end
        pulses("t5_ovf");
        for (int k = 0; k < 4; k++) read_one("t5_rd");
        fifo_state("t5_drained");
        for (int k = 8'h11; k <= 8'h14; k++) good(8'(k));
        fifo_state("t5_full");
        exp_head = q.pop_front();
        send_frame(8'h15, ~^8'h15, 1'b1, 11, 1'b1, -1);
        q.push_back(8'h15);
        e_done++;
        repeat (20) @(negedge clk);
        pulses("t5_pp");
        fifo_state("t5_pp");
        for (int k = 0; k < 4; k++) read_one("t5_pp_rd");

        ps2d = 1'b0;
        repeat (20) @(negedge clk);
        ps2c = 1'b0;
        repeat (7) @(negedge clk);
        ps2c = 1'b1;
        repeat (20) @(negedge clk);
        ps2d = 1'b1;
        repeat (100) @(negedge clk);
        send_frame(8'hA5, ~^8'hA5, 1'b1, 11, 1'b0, 4);
        q.push_back(8'hA5);
        e_done++;
        repeat (20) @(negedge clk);
        pulses("t6_glitch");
        read_one("t6_glitch");

        good(8'h3C);
        send_frame(8'h77, 1'b0, 1'b1, 4, 1'b0, -1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        q.delete();
        fifo_state("t6_rst");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        good(8'hC3);
        pulses("t6_after");
        read_one("t6_after");

        rx_en = 1'b0;
        send_frame(8'h66, ~^8'h66, 1'b1, 11, 1'b0, -1);
        rx_en = 1'b1;
        repeat (20) @(negedge clk);
        pulses("rxen");
        fifo_state("rxen");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
